// File: rtl/longmult_wb_sequencer.sv
// longmult_wb_sequencer: launches the long multiply, adds the accumulator and retires RdLo then RdHi through banked write enables
module longmult_wb_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic        FlushE,
  input  logic        SignedE,
  input  logic        AccumulateE,
  input  logic        SetFlagsE,
  input  logic [3:0]  RdLoE,
  input  logic [3:0]  RdHiE,
  input  logic [11:0] StatusRegisterE,
  input  logic [31:0] AccLoE,
  input  logic [31:0] AccHiE,
  input  logic        MulDoneE,
  input  logic [63:0] ProductE,
  output logic        MulStartE,
  output logic        MulSignedE,
  output logic [31:0] WriteEnW,
  output logic [31:0] WriteDataW,
  output logic        FlagWrE,
  output logic        FlagNE,
  output logic        FlagZE,
  output logic        StallLM,
  output logic        BadDestE,
  output logic        DoneE
);
  typedef enum logic [1:0] {IDLE, WAIT_MUL, WB_LO, WB_HI} state_t;
  state_t      state;
  logic [3:0]  rd_lo, rd_hi;
  logic [4:0]  mode;
  logic        acc, set_flags;
  logic [63:0] acc_val, result, sum;
  logic        go;
  logic        unused_ok;
  // R13/R14 sit at a per-mode offset; FIQ also banks R8-R12, so every FIQ register from R8 up shifts by 16
  function automatic logic [31:0] bank(input logic [4:0] m, input logic [3:0] rd);
    logic [31:0] one;
    logic [4:0]  off;
    logic        ok;
    one = 32'h1;
    ok  = 1'b1;
    off = 5'd0;
    case (m)
      5'b10000, 5'b11111: off = 5'd0;
      5'b10011:           off = 5'd3;
      5'b10111:           off = 5'd5;
      5'b11011:           off = 5'd7;
      5'b10010:           off = 5'd9;
      5'b10001:           off = 5'd16;
      default:            ok  = 1'b0;
    endcase
    return (!ok || rd == 4'd15) ? 32'h0 :
           (rd < 4'd8 || (rd < 4'd13 && m != 5'b10001)) ? one << rd : one << ({1'b0, rd} + off);
  endfunction
  assign go         = state == IDLE && StartE && !FlushE;
  assign MulStartE  = go;
  assign MulSignedE = go & SignedE;
  assign StallLM    = go || state == WAIT_MUL || state == WB_LO;
  assign sum        = ProductE + (acc ? acc_val : 64'h0);
  assign unused_ok  = ^StatusRegisterE[11:5];
  // sequencer: capture, wait for product, then two registered write beats
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rd_lo      <= '0;
      rd_hi      <= '0;
      mode       <= '0;
      acc        <= 1'b0;
      set_flags  <= 1'b0;
      acc_val    <= '0;
      result     <= '0;
      WriteEnW   <= '0;
      WriteDataW <= '0;
      FlagWrE    <= 1'b0;
      FlagNE     <= 1'b0;
      FlagZE     <= 1'b0;
      BadDestE   <= 1'b0;
      DoneE      <= 1'b0;
    end else begin
      WriteEnW   <= '0;
      WriteDataW <= '0;
      FlagWrE    <= 1'b0;
      FlagNE     <= 1'b0;
      FlagZE     <= 1'b0;
      BadDestE   <= 1'b0;
      DoneE      <= 1'b0;
      case (state)
        IDLE: if (go) begin
          rd_lo     <= RdLoE;
          rd_hi     <= RdHiE;
          mode      <= StatusRegisterE[4:0];
          acc       <= AccumulateE;
          set_flags <= SetFlagsE;
          acc_val   <= {AccHiE, AccLoE};
          state     <= WAIT_MUL;
        end
        WAIT_MUL: if (FlushE) state <= IDLE;
        else if (MulDoneE) begin
          result     <= sum;
          WriteEnW   <= bank(mode, rd_lo);
          WriteDataW <= sum[31:0];
          BadDestE   <= rd_lo == 4'd15;
          state      <= WB_LO;
        end
        WB_LO: begin
          WriteEnW   <= bank(mode, rd_hi);
          WriteDataW <= result[63:32];
          BadDestE   <= rd_hi == 4'd15;
          DoneE      <= 1'b1;
          FlagWrE    <= set_flags;
          FlagNE     <= set_flags & result[63];
          FlagZE     <= set_flags & (result == 64'h0);
          state      <= WB_HI;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_longmult_wb_sequencer.sv
// tb_longmult_wb_sequencer: transaction-level model plus directed multiply-long sequences
module tb_longmult_wb_sequencer;
  logic        clk = 0, reset = 1;
  logic        StartE = 0, FlushE = 0, SignedE = 0, AccumulateE = 0, SetFlagsE = 0, MulDoneE = 0;
  logic [3:0]  RdLoE = 0, RdHiE = 0;
  logic [11:0] StatusRegisterE = 0;
  logic [31:0] AccLoE = 0, AccHiE = 0;
  logic [63:0] ProductE = 0;
  logic        MulStartE, MulSignedE, FlagWrE, FlagNE, FlagZE, StallLM, BadDestE, DoneE;
  logic [31:0] WriteEnW, WriteDataW;
  int vectors = 0, miscompares = 0;
  longmult_wb_sequencer dut (
    .clk(clk), .reset(reset), .StartE(StartE), .FlushE(FlushE), .SignedE(SignedE),
    .AccumulateE(AccumulateE), .SetFlagsE(SetFlagsE), .RdLoE(RdLoE), .RdHiE(RdHiE),
    .StatusRegisterE(StatusRegisterE), .AccLoE(AccLoE), .AccHiE(AccHiE), .MulDoneE(MulDoneE),
    .ProductE(ProductE), .MulStartE(MulStartE), .MulSignedE(MulSignedE), .WriteEnW(WriteEnW),
    .WriteDataW(WriteDataW), .FlagWrE(FlagWrE), .FlagNE(FlagNE), .FlagZE(FlagZE),
    .StallLM(StallLM), .BadDestE(BadDestE), .DoneE(DoneE)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [31:0] we, d; logic bad, done, fw, n, z;} beat_t;
  beat_t       q[$];
  logic        waiting = 0, idle, armed = 0;
  logic [4:0]  m_mode;
  logic [3:0]  m_lo, m_hi;
  logic        m_acc, m_s;
  logic [63:0] m_accv, r;
  function automatic logic [31:0] en(input logic [4:0] m, input logic [3:0] rd);
    int b;
    b = -1;
    if (m inside {5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1b, 5'h1f} && rd != 4'd15) begin
      if (rd < 8 || (rd < 13 && m != 5'h11)) b = rd;
      else if (m == 5'h11) b = rd + 16;
      else case (m)
        5'h13: b = rd + 3;
        5'h17: b = rd + 5;
        5'h1b: b = rd + 7;
        5'h12: b = rd + 9;
        default: b = rd;
      endcase
    end
    return b < 0 ? 32'h0 : 32'h1 << b;
  endfunction
  always @(posedge clk) begin
    armed <= 1'b1;
    if (reset) begin
      q.delete();
      waiting = 0;
    end else begin
      idle = !waiting && q.size() == 0;
      if (q.size() != 0) void'(q.pop_front());
      if (idle && StartE && !FlushE) begin
        waiting = 1;
        m_mode = StatusRegisterE[4:0]; m_lo = RdLoE; m_hi = RdHiE;
        m_acc = AccumulateE; m_s = SetFlagsE; m_accv = {AccHiE, AccLoE};
      end else if (waiting && FlushE) waiting = 0;
      else if (waiting && MulDoneE) begin
        r = ProductE + (m_acc ? m_accv : 64'h0);
        q.push_back('{en(m_mode, m_lo), r[31:0], m_lo == 15, 1'b0, 1'b0, 1'b0, 1'b0});
        q.push_back('{en(m_mode, m_hi), r[63:32], m_hi == 15, 1'b1, m_s, m_s & r[63], m_s & (r == 0)});
        waiting = 0;
      end
    end
  end
  always @(negedge clk) if (armed) begin
    logic        st;
    beat_t       cur;
    logic [71:0] act, exp;
    st  = !waiting && q.size() == 0 && StartE && !FlushE;
    cur = q.size() != 0 ? q[0] : '0;
    exp = {st, st & SignedE, cur.we, cur.d, cur.fw, cur.n, cur.z, st | waiting | (q.size() == 2), cur.bad, cur.done};
    act = {MulStartE, MulSignedE, WriteEnW, WriteDataW, FlagWrE, FlagNE, FlagZE, StallLM, BadDestE, DoneE};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL cycle t=%0t got %h expected %h", $time, act, exp);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", name, a, e);
    end
  endtask
  logic [31:0] lo_we, lo_d, hi_we, hi_d;
  logic        lo_bad, hi_bad, hi_done, fw, fn, fz;
  int          stalls;
  task automatic op(input logic [4:0] m, input logic sg, input logic ac, input logic s,
                    input logic [3:0] lo, input logic [3:0] hi, input logic [63:0] acc,
                    input logic [63:0] prod, input int k, input int poke);
    stalls = 0;
    for (int c = 0; c <= k + 2; c++) begin
      StartE   = c == 0 || c == poke;
      MulDoneE = c == k || c == 0;
      ProductE = c == k ? prod : 64'hDEAD_BEEF_0BAD_F00D;
      StatusRegisterE = c == 0 ? {7'h55, m} : 12'h0;
      {SignedE, AccumulateE, SetFlagsE} = c == 0 ? {sg, ac, s} : ~{sg, ac, s};
      {RdLoE, RdHiE} = c == 0 ? {lo, hi} : ~{lo, hi};
      {AccHiE, AccLoE} = c == 0 ? acc : ~acc;
      @(negedge clk);
      stalls += int'(StallLM);
      if (c == k + 1) begin lo_we = WriteEnW; lo_d = WriteDataW; lo_bad = BadDestE; end
      if (c == k + 2) begin
        hi_we = WriteEnW; hi_d = WriteDataW; hi_bad = BadDestE;
        hi_done = DoneE; fw = FlagWrE; fn = FlagNE; fz = FlagZE;
      end
      tick();
    end
    StartE = 0; MulDoneE = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", WriteEnW, 0);
    chk("rst_data", WriteDataW, 0);
    chk("rst_misc", {MulStartE, FlagWrE, FlagNE, FlagZE, StallLM, DoneE, BadDestE}, 0);
    tick();
    reset = 0;
    op(5'h10, 0, 0, 0, 2, 3, 0, 64'h0000_0001_FFFF_FFFE, 1, -1);
    chk("umull_lo_we", lo_we, 32'h4);
    chk("umull_lo_d", lo_d, 32'hFFFF_FFFE);
    chk("umull_hi_we", hi_we, 32'h8);
    chk("umull_hi_d", hi_d, 32'h1);
    chk("umull_done", hi_done, 1);
    chk("umull_stalls", stalls, 3);
    op(5'h11, 1, 1, 1, 8, 13, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1, -1);
    chk("fiq_we", {lo_we, hi_we}, {32'h0100_0000, 32'h2000_0000});
    chk("fiq_data", {lo_d, hi_d}, 0);
    chk("fiq_flags", {fw, fn, fz}, 3'b101);
    op(5'h13, 0, 0, 0, 14, 15, 0, 64'h0000_0005_0000_0007, 2, -1);
    chk("svc_lo_we", lo_we, 32'h0002_0000);
    chk("svc_hi_we", hi_we, 0);
    chk("svc_bad", {lo_bad, hi_bad}, 2'b01);
    op(5'h12, 0, 1, 1, 13, 14, 64'h0000_0001_0000_0001, 64'h1234_5678_9ABC_DEF0, 5, 3);
    chk("delay_stalls", stalls, 7);
    chk("irq_we", {lo_we, hi_we}, {32'h0040_0000, 32'h0080_0000});
    chk("acc_data", {lo_d, hi_d}, {32'h9ABC_DEF1, 32'h1234_5679});
    chk("acc_flags", {fw, fn, fz}, 3'b100);
    op(5'h00, 0, 0, 0, 13, 1, 0, 64'h77, 2, -1);
    chk("badmode_we", {lo_we, hi_we}, 0);
    op(5'h1f, 0, 0, 0, 5, 5, 0, 64'h0000_0002_0000_0001, 1, -1);
    chk("same_rd_we", {lo_we, hi_we}, {32'h20, 32'h20});
    op(5'h1b, 1, 0, 1, 14, 12, 0, 64'h8000_0000_0000_0000, 3, -1);
    chk("und_we", {lo_we, hi_we}, {32'h0020_0000, 32'h0000_1000});
    chk("neg_flags", {fw, fn, fz}, 3'b110);
    StatusRegisterE = 12'h010; RdLoE = 1; RdHiE = 2; StartE = 1;
    tick();
    StartE = 0;
    tick();
    FlushE = 1; MulDoneE = 1;
    @(negedge clk);
    chk("flush_stall", StallLM, 1);
    tick();
    FlushE = 0; MulDoneE = 0;
    stalls = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      stalls += int'(WriteEnW != 0 || DoneE || StallLM);
      tick();
    end
    chk("flush_quiet", stalls, 0);
    StatusRegisterE = 12'h010; RdLoE = 4; RdHiE = 5; StartE = 1;
    tick();
    StartE = 0; MulDoneE = 1; ProductE = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    MulDoneE = 0; reset = 1;
    @(negedge clk);
    chk("rst_wblo_we", WriteEnW, 32'h10);
    tick();
    reset = 0;
    @(negedge clk);
    chk("rst_wbhi_out", {WriteEnW, WriteDataW, DoneE, StallLM}, 0);
    tick();
    @(negedge clk);
    chk("rst_after_we", WriteEnW, 0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/longmult_wb_sequencer.md
# longmult_wb_sequencer

Sequencer for multiply-long instructions (UMULL/SMULL/UMLAL/SMLAL) in the Execute stage of the pipelined core. It launches the external 32x32 multiplier, optionally adds the 64-bit accumulator, and retires the result through the single register-file write port in two cycles: RdLo, then RdHi. Each write uses a mode-banked one-hot enable. The block stalls the front of the pipeline while busy and updates N/Z when the S bit is set.

## Interface
- No parameters.
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- StartE  in  1  multiply-long instruction valid in Execute.
- FlushE  in  1  squash the in-flight instruction.
- SignedE  in  1  signed multiply (SMULL/SMLAL).
- AccumulateE  in  1  accumulate form (UMLAL/SMLAL).
- SetFlagsE  in  1  S bit.
- RdLoE  in  4  low-destination register number.
- RdHiE  in  4  high-destination register number.
- StatusRegisterE  in  12  CPSR slice; bits [4:0] are the mode.
- AccLoE, AccHiE  in  32 each  current RdLo/RdHi values; used when AccumulateE=1.
- MulDoneE  in  1  multiplier result valid.
- ProductE  in  64  multiplier result; valid only while MulDoneE=1.
- MulStartE  out  1  launch pulse to the multiplier.
- MulSignedE  out  1  signedness forwarded to the multiplier.
- WriteEnW  out  32  one-hot banked register write enable.
- WriteDataW  out  32  write data.
- FlagWrE  out  1  write N/Z.
- FlagNE, FlagZE  out  1 each  flag values.
- StallLM  out  1  stall the pipeline stages before Execute.
- BadDestE  out  1  one-cycle pulse when an R15 destination is suppressed.
- DoneE  out  1  one-cycle pulse on the final write.

## Operation
- States: IDLE, WAIT_MUL, WB_LO, WB_HI.
- IDLE: when StartE=1 and FlushE=0:
  - MulStartE=1 (combinational); MulSignedE=SignedE.
  - Capture RdLo, RdHi, mode[4:0], AccumulateE, SetFlagsE, {AccHiE,AccLoE}.
  - Go to WAIT_MUL.
- WAIT_MUL:
  - FlushE=1 -> IDLE; no writes, no flags.
  - Else if MulDoneE=1 -> Result = ProductE + (acc ? {AccHi,AccLo} : 0), modulo 2^64, registered. Go to WB_LO.
  - Otherwise hold. There is no timeout.
- WB_LO: WriteEnW=decode(RdLo), WriteDataW=Result[31:0]. Go to WB_HI. FlushE is ignored (instruction has committed).
- WB_HI: WriteEnW=decode(RdHi), WriteDataW=Result[63:32]. DoneE=1. If S: FlagWrE=1, FlagNE=Result[63], FlagZE=(Result==0). Go to IDLE.
- Banked decode uses the captured mode, so later CPSR changes do not affect the writes.
  - R0–R7 -> bits 0–7 in every valid mode.
  - R8–R12 -> bits 8–12 except in FIQ, where they map to bits 24–28.
  - R13/R14 by mode:
    - usr (10000)/sys (11111) -> bits 13/14
    - svc (10011) -> 16/17
    - abt (10111) -> 18/19
    - und (11011) -> 20/21
    - irq (10010) -> 22/23
    - fiq (10001) -> 29/30
  - Any other mode value -> all-zero enable.
- R15 destination: that half's enable is forced to 0 and BadDestE pulses in that write cycle. The other half is still written.
- RdLo==RdHi: both writes occur; the RdHi write lands last and wins.
- StartE while not IDLE is ignored.
- StallLM = (IDLE & StartE & ~FlushE) | WAIT_MUL | WB_LO.

## Timing
- Reset: state IDLE, result/capture registers 0. All outputs 0: WriteEnW=32'h0, WriteDataW=0, flags 0, StallLM=0, DoneE=0, MulStartE=0.
- Reset mid-operation takes effect next edge: IDLE, no further writes.
- Sequence: StartE at cycle 0; MulDoneE earliest at cycle 1 (accepted at k≥1); WB_LO at k+1; WB_HI and DoneE at k+2.
- StallLM is high in cycles 0..k+1 and low in k+2, so the next instruction enters Execute at k+3.
- A MulDoneE coinciding with StartE in IDLE is ignored.
- FlushE together with MulDoneE in WAIT_MUL: the flush wins.
- When not writing, WriteEnW=32'h0 and WriteDataW=0.

## Test plan
- usr mode, UMULL RdLo=2, RdHi=3, ProductE=64'h0000_0001_FFFF_FFFE at k=1 -> cycle 2: WriteEnW=32'h4, data FFFFFFFE; cycle 3: WriteEnW=32'h8, data 00000001, DoneE=1.
- fiq mode (10001), SMLAL S=1, RdLo=8, RdHi=13, Acc=64'h1, ProductE=64'hFFFF_FFFF_FFFF_FFFF -> writes 32'h01000000 then 32'h20000000, both data 0; FlagWrE=1, Z=1, N=0.
- svc mode, RdLo=14, RdHi=15 -> first write WriteEnW=32'h00020000; second write WriteEnW=0 with BadDestE=1.
- MulDoneE delayed to k=5 -> StallLM high in cycles 0–6, writes in cycles 6/7; StartE pulsed at cycle 3 has no effect.
- FlushE at cycle 2 in WAIT_MUL -> IDLE, no writes; reset asserted in WB_LO -> WB_HI write never occurs and outputs go to 0.
- Invalid mode 5'b00000, RdLo=13, RdHi=1 -> first write WriteEnW=0; second write WriteEnW=0.
